// File: rtl/alt_vipcti_packet_fifo.sv
// Packet FIFO for the clocked-video-input path: whole lines are committed on eop,
// and a line that cannot fit is rolled back and discarded up to its eop.
module alt_vipcti_packet_fifo #(
  parameter int DATA_WIDTH  = 20,
  parameter int FIFO_DEPTH  = 1920,
  parameter int SHOWAHEAD   = 0,
  parameter int DATA_WIDTHU = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   aclr_n,
  input  logic                   sclr,
  input  logic                   wr_valid,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_sop,
  input  logic                   wr_eop,
  input  logic                   rd_req,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_sop,
  output logic                   rd_eop,
  output logic                   rd_empty,
  output logic [DATA_WIDTHU-1:0] rd_usedw,
  output logic [DATA_WIDTHU-1:0] wr_usedw,
  output logic                   overflow,
  output logic                   stray,
  output logic [15:0]            drop_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int MW = DATA_WIDTH + 2;
  localparam logic [PW-1:0]          LAST_P  = PW'(FIFO_DEPTH - 1);
  localparam logic [DATA_WIDTHU-1:0] DEPTH_C = DATA_WIDTHU'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    DROP   = 2'd2
  } wr_state_t;

  wr_state_t state, state_nx;

  logic [MW-1:0]          mem [FIFO_DEPTH];
  logic [PW-1:0]          wptr, cptr, rptr;
  logic [PW-1:0]          wbase, wptr_nx, cptr_nx;
  logic [DATA_WIDTHU-1:0] wr_cnt, rd_cnt, wr_cnt_nx, rd_cnt_nx;
  logic [DATA_WIDTHU-1:0] pend, cnt_base, pend_base;
  logic                   we, cm, rb, pop, stray_nx;
  logic [1:0]             drop_inc;
  logic [16:0]            drop_sum;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  // Write side never stalls: every wr_valid word is stored, dropped or flagged stray.
  // Read side: a word is consumed on a clock where rd_req is high and rd_empty is low.
  always_comb begin
    state_nx = state;
    we       = 1'b0;
    cm       = 1'b0;
    rb       = 1'b0;
    drop_inc = 2'd0;
    stray_nx = 1'b0;
    if (wr_valid) begin
      case (state)
        IDLE, DROP: begin
          if (wr_sop) begin
            if (wr_cnt < DEPTH_C) begin
              we = 1'b1;
              if (wr_eop) begin
                cm       = 1'b1;
                state_nx = IDLE;
              end else begin
                state_nx = IN_PKT;
              end
            end else begin
              drop_inc = 2'd1;
              state_nx = wr_eop ? IDLE : DROP;
            end
          end else if (state == IDLE) begin
            stray_nx = 1'b1;
          end else if (wr_eop) begin
            state_nx = IDLE;
          end
        end
        IN_PKT: begin
          if (wr_sop) begin
            // Restart: abandon the open packet, then treat the word as a fresh sop.
            rb       = 1'b1;
            drop_inc = 2'd1;
            if (rd_cnt < DEPTH_C) begin
              we = 1'b1;
              if (wr_eop) begin
                cm       = 1'b1;
                state_nx = IDLE;
              end else begin
                state_nx = IN_PKT;
              end
            end else begin
              drop_inc = 2'd2;
              state_nx = wr_eop ? IDLE : DROP;
            end
          end else if (!(wr_cnt < DEPTH_C)) begin
            rb       = 1'b1;
            drop_inc = 2'd1;
            state_nx = wr_eop ? IDLE : DROP;
          end else begin
            we = 1'b1;
            if (wr_eop) begin
              cm       = 1'b1;
              state_nx = IDLE;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign pend      = wr_cnt - rd_cnt;
  assign wbase     = rb ? cptr : wptr;
  assign cnt_base  = rb ? rd_cnt : wr_cnt;
  assign pend_base = rb ? '0 : pend;
  assign wptr_nx   = we ? ptr_inc(wbase) : wbase;
  assign cptr_nx   = cm ? wptr_nx : cptr;
  assign wr_cnt_nx = cnt_base + DATA_WIDTHU'(we) - DATA_WIDTHU'(pop);
  assign rd_cnt_nx = rd_cnt + (cm ? pend_base + DATA_WIDTHU'(1) : '0) - DATA_WIDTHU'(pop);
  assign drop_sum  = {1'b0, drop_count} + {15'd0, drop_inc};

  assign wr_usedw = wr_cnt;
  assign rd_usedw = rd_cnt;

  always_ff @(posedge clock) begin
    if (we) mem[wbase] <= {wr_sop, wr_eop, wr_data};
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state      <= IDLE;
      wptr       <= '0;
      cptr       <= '0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      overflow   <= 1'b0;
      stray      <= 1'b0;
      drop_count <= '0;
    end else if (sclr) begin
      state    <= IDLE;
      wptr     <= '0;
      cptr     <= '0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      overflow <= 1'b0;
      stray    <= 1'b0;
    end else begin
      state      <= state_nx;
      wptr       <= wptr_nx;
      cptr       <= cptr_nx;
      wr_cnt     <= wr_cnt_nx;
      rd_cnt     <= rd_cnt_nx;
      overflow   <= (drop_inc != 2'd0);
      stray      <= stray_nx;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign pop = rd_req && !rd_empty;

  generate
    if (SHOWAHEAD != 0) begin : g_showahead
      // Two-stage prefetch: q1 is the RAM output, rd_data the presented head word.
      logic [MW-1:0]          q1;
      logic                   v1, adv, fetch;
      logic [DATA_WIDTHU-1:0] inflight;

      assign inflight = DATA_WIDTHU'(v1) + DATA_WIDTHU'(!rd_empty);
      assign adv      = v1 && (rd_empty || pop);
      assign fetch    = (rd_cnt > inflight) && (!v1 || adv);

      always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
          rptr     <= '0;
          q1       <= '0;
          v1       <= 1'b0;
          rd_empty <= 1'b1;
          rd_data  <= '0;
          rd_sop   <= 1'b0;
          rd_eop   <= 1'b0;
        end else if (sclr) begin
          rptr     <= '0;
          v1       <= 1'b0;
          rd_empty <= 1'b1;
        end else begin
          if (fetch) begin
            q1   <= mem[rptr];
            rptr <= ptr_inc(rptr);
          end
          v1 <= fetch || (v1 && !adv);
          if (adv) {rd_sop, rd_eop, rd_data} <= q1;
          rd_empty <= !(adv || (!rd_empty && !pop));
        end
      end
    end else begin : g_normal
      logic [PW-1:0] raddr_q;
      logic          rd_pend;

      always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
          rptr     <= '0;
          raddr_q  <= '0;
          rd_pend  <= 1'b0;
          rd_empty <= 1'b1;
          rd_data  <= '0;
          rd_sop   <= 1'b0;
          rd_eop   <= 1'b0;
        end else if (sclr) begin
          rptr     <= '0;
          rd_pend  <= 1'b0;
          rd_empty <= 1'b1;
        end else begin
          rd_empty <= (rd_cnt_nx == '0);
          rd_pend  <= pop;
          if (pop) begin
            raddr_q <= rptr;
            rptr    <= ptr_inc(rptr);
          end
          if (rd_pend) {rd_sop, rd_eop, rd_data} <= mem[raddr_q];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_alt_vipcti_packet_fifo.sv
// Directed bench for alt_vipcti_packet_fifo: a normal-mode instance (depth 8) and a
// show-ahead instance, with expected read words held in scoreboard queues.
module tb_alt_vipcti_packet_fifo;

  localparam int DW  = 8;
  localparam int DEP = 8;
  localparam int UW  = $clog2(DEP + 1);

  logic          clk = 1'b0;
  logic          aclr_n;
  logic          sclr, wr_valid, wr_sop, wr_eop, rd_req;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_sop, rd_eop, rd_empty, overflow, stray;
  logic [UW-1:0] rd_usedw, wr_usedw;
  logic [15:0]   drop_count;

  logic          sa_wr_valid, sa_wr_sop, sa_wr_eop, sa_rd_req;
  logic [DW-1:0] sa_wr_data, sa_rd_data;
  logic          sa_rd_sop, sa_rd_eop, sa_rd_empty, sa_overflow, sa_stray;
  logic [UW-1:0] sa_rd_usedw, sa_wr_usedw;
  logic [15:0]   sa_drop_count;

  int checks = 0;
  int errors = 0;
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] sa_q[$];

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  alt_vipcti_packet_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEP), .SHOWAHEAD(0)) dut (
    .clock(clk), .aclr_n(aclr_n), .sclr(sclr),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_sop(wr_sop), .wr_eop(wr_eop),
    .rd_req(rd_req), .rd_data(rd_data), .rd_sop(rd_sop), .rd_eop(rd_eop),
    .rd_empty(rd_empty), .rd_usedw(rd_usedw), .wr_usedw(wr_usedw),
    .overflow(overflow), .stray(stray), .drop_count(drop_count)
  );

  alt_vipcti_packet_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEP), .SHOWAHEAD(1)) dut_sa (
    .clock(clk), .aclr_n(aclr_n), .sclr(sclr),
    .wr_valid(sa_wr_valid), .wr_data(sa_wr_data), .wr_sop(sa_wr_sop), .wr_eop(sa_wr_eop),
    .rd_req(sa_rd_req), .rd_data(sa_rd_data), .rd_sop(sa_rd_sop), .rd_eop(sa_rd_eop),
    .rd_empty(sa_rd_empty), .rd_usedw(sa_rd_usedw), .wr_usedw(sa_wr_usedw),
    .overflow(sa_overflow), .stray(sa_stray), .drop_count(sa_drop_count)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic wr_word(input logic sop, input logic eop, input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_sop   = sop;
    wr_eop   = eop;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    wr_sop   = 1'b0;
    wr_eop   = 1'b0;
  endtask

  task automatic sa_wr_word(input logic sop, input logic eop, input logic [DW-1:0] d);
    sa_wr_valid = 1'b1;
    sa_wr_sop   = sop;
    sa_wr_eop   = eop;
    sa_wr_data  = d;
    tick();
    sa_wr_valid = 1'b0;
    sa_wr_sop   = 1'b0;
    sa_wr_eop   = 1'b0;
  endtask

  // Pop one word; the data appears one clock after the edge that samples rd_req.
  task automatic rd_word(input string tag, input logic chk_lat, input logic [DW-1:0] stale);
    logic [DW+1:0] exp;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    if (chk_lat) check({tag, "_latency"}, 32'(rd_data), 32'(stale));
    tick();
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed %0h expected none (queue empty)", tag, {rd_sop, rd_eop, rd_data});
    end else begin
      exp = exp_q.pop_front();
      check(tag, 32'({rd_sop, rd_eop, rd_data}), 32'(exp));
    end
  endtask

  task automatic sa_check_head(input string tag);
    logic [DW+1:0] exp;
    if (sa_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed %0h expected none (queue empty)", tag, {sa_rd_sop, sa_rd_eop, sa_rd_data});
    end else begin
      exp = sa_q.pop_front();
      check(tag, 32'({sa_rd_sop, sa_rd_eop, sa_rd_data}), 32'(exp));
    end
  endtask

  initial begin
    aclr_n = 1'b1;
    sclr = 1'b0; wr_valid = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0; wr_data = '0; rd_req = 1'b0;
    sa_wr_valid = 1'b0; sa_wr_sop = 1'b0; sa_wr_eop = 1'b0; sa_wr_data = '0; sa_rd_req = 1'b0;
    #1 aclr_n = 1'b0;
    tick();
    tick();
    check("rst_rd_empty", 32'(rd_empty), 32'd1);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_usedw", 32'({rd_usedw, wr_usedw}), 32'd0);
    check("rst_flags", 32'({overflow, stray, rd_sop, rd_eop}), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_sa_rd_empty", 32'(sa_rd_empty), 32'd1);
    aclr_n = 1'b1;
    tick();

    // 3-word packet, then three pops
    wr_word(1'b1, 1'b0, 8'h11);
    check("p1_w1_rd_usedw", 32'(rd_usedw), 32'd0);
    check("p1_w1_wr_usedw", 32'(wr_usedw), 32'd1);
    wr_word(1'b0, 1'b0, 8'h22);
    check("p1_w2_rd_usedw", 32'(rd_usedw), 32'd0);
    check("p1_w2_rd_empty", 32'(rd_empty), 32'd1);
    wr_word(1'b0, 1'b1, 8'h33);
    exp_q.push_back({1'b1, 1'b0, 8'h11});
    exp_q.push_back({1'b0, 1'b0, 8'h22});
    exp_q.push_back({1'b0, 1'b1, 8'h33});
    check("p1_commit_rd_usedw", 32'(rd_usedw), 32'd3);
    check("p1_commit_rd_empty", 32'(rd_empty), 32'd0);
    rd_word("p1_rd0", 1'b1, 8'h00);
    rd_word("p1_rd1", 1'b0, 8'h00);
    rd_word("p1_rd2", 1'b0, 8'h00);
    check("p1_drained_empty", 32'(rd_empty), 32'd1);
    check("p1_drained_usedw", 32'({rd_usedw, wr_usedw}), 32'd0);

    // Committed 5-word packet, then a 6-word packet that overflows
    for (int i = 0; i < 5; i++) begin
      wr_word(i == 0, i == 4, 8'(8'h50 + i));
      exp_q.push_back({i == 0, i == 4, 8'(8'h50 + i)});
    end
    check("p2_committed", 32'(rd_usedw), 32'd5);
    for (int i = 0; i < 3; i++) wr_word(i == 0, 1'b0, 8'(8'h60 + i));
    check("p2_full_wr_usedw", 32'(wr_usedw), 32'd8);
    check("p2_full_no_ovf", 32'(overflow), 32'd0);
    wr_word(1'b0, 1'b0, 8'h63);
    check("p2_ovf_pulse", 32'(overflow), 32'd1);
    check("p2_rollback_wr_usedw", 32'(wr_usedw), 32'd5);
    check("p2_drop_count", 32'(drop_count), 32'd1);
    wr_word(1'b0, 1'b0, 8'h64);
    check("p2_ovf_one_cycle", 32'(overflow), 32'd0);
    wr_word(1'b0, 1'b1, 8'h65);
    check("p2_after_eop_usedw", 32'({rd_usedw, wr_usedw}), 32'({4'd5, 4'd5}));
    for (int i = 0; i < 5; i++) rd_word("p2_rd", 1'b0, 8'h00);
    check("p2_drained_empty", 32'(rd_empty), 32'd1);

    // Stray word, then restart mid-packet
    wr_word(1'b0, 1'b0, 8'h77);
    check("stray_pulse", 32'(stray), 32'd1);
    check("stray_counts", 32'({rd_usedw, wr_usedw}), 32'd0);
    check("stray_no_drop", 32'(drop_count), 32'd1);
    tick();
    check("stray_one_cycle", 32'(stray), 32'd0);
    wr_word(1'b1, 1'b0, 8'h80);
    wr_word(1'b0, 1'b0, 8'h81);
    wr_word(1'b1, 1'b0, 8'h90);
    check("restart_ovf", 32'(overflow), 32'd1);
    check("restart_drop_count", 32'(drop_count), 32'd2);
    check("restart_wr_usedw", 32'(wr_usedw), 32'd1);
    wr_word(1'b0, 1'b0, 8'h91);
    wr_word(1'b0, 1'b1, 8'h92);
    exp_q.push_back({1'b1, 1'b0, 8'h90});
    exp_q.push_back({1'b0, 1'b0, 8'h91});
    exp_q.push_back({1'b0, 1'b1, 8'h92});
    check("restart_rd_usedw", 32'(rd_usedw), 32'd3);
    for (int i = 0; i < 3; i++) rd_word("restart_rd", 1'b0, 8'h00);

    // Pointer wrap: single-word packets popped as they commit
    for (int i = 0; i < 20; i++) begin
      logic [DW-1:0] d;
      d = 8'($urandom_range(0, 255));
      wr_word(1'b1, 1'b1, d);
      exp_q.push_back({1'b1, 1'b1, d});
      rd_word("wrap_rd", 1'b0, 8'h00);
    end
    check("wrap_empty", 32'(rd_empty), 32'd1);
    check("wrap_usedw", 32'({rd_usedw, wr_usedw}), 32'd0);

    // Show-ahead instance
    sa_wr_word(1'b1, 1'b0, 8'hA0);
    sa_wr_word(1'b0, 1'b1, 8'hA1);
    sa_q.push_back({1'b1, 1'b0, 8'hA0});
    sa_q.push_back({1'b0, 1'b1, 8'hA1});
    check("sa_commit_usedw", 32'(sa_rd_usedw), 32'd2);
    check("sa_empty_c0", 32'(sa_rd_empty), 32'd1);
    tick();
    check("sa_empty_c1", 32'(sa_rd_empty), 32'd1);
    tick();
    check("sa_empty_c2", 32'(sa_rd_empty), 32'd0);
    sa_check_head("sa_head0");
    sa_rd_req = 1'b1;
    tick();
    sa_rd_req = 1'b0;
    check("sa_after_pop0_empty", 32'(sa_rd_empty), 32'd0);
    sa_check_head("sa_head1");
    sa_rd_req = 1'b1;
    tick();
    sa_rd_req = 1'b0;
    check("sa_drained_empty", 32'(sa_rd_empty), 32'd1);
    check("sa_drained_usedw", 32'(sa_rd_usedw), 32'd0);

    // Asynchronous reset mid-packet and mid-read
    wr_word(1'b1, 1'b0, 8'h41);
    wr_word(1'b0, 1'b1, 8'h42);
    wr_word(1'b1, 1'b0, 8'h43);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    aclr_n = 1'b0;
    #1;
    check("arst_rd_empty", 32'(rd_empty), 32'd1);
    check("arst_rd_data", 32'({rd_sop, rd_eop, rd_data}), 32'd0);
    check("arst_usedw", 32'({rd_usedw, wr_usedw}), 32'd0);
    check("arst_drop_count", 32'(drop_count), 32'd0);
    check("arst_flags", 32'({overflow, stray}), 32'd0);
    exp_q.delete();
    tick();
    aclr_n = 1'b1;
    tick();

    // sclr with 4 words stored keeps drop_count
    wr_word(1'b1, 1'b0, 8'h01);
    wr_word(1'b1, 1'b0, 8'h02);
    wr_word(1'b0, 1'b0, 8'h03);
    wr_word(1'b0, 1'b1, 8'h04);
    wr_word(1'b1, 1'b0, 8'h05);
    check("sclr_pre_usedw", 32'({rd_usedw, wr_usedw}), 32'({4'd3, 4'd4}));
    check("sclr_pre_drop", 32'(drop_count), 32'd1);
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    check("sclr_usedw", 32'({rd_usedw, wr_usedw}), 32'd0);
    check("sclr_empty", 32'(rd_empty), 32'd1);
    check("sclr_drop_kept", 32'(drop_count), 32'd1);
    wr_word(1'b1, 1'b1, 8'h3C);
    exp_q.push_back({1'b1, 1'b1, 8'h3C});
    rd_word("sclr_post_rd", 1'b0, 8'h00);
    check("final_empty", 32'(rd_empty), 32'd1);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
